data_memory_mc: RTL and testbench
=================================

Name: data_memory_mc

Overview:
- Parametrised, multi-cycle successor to the pipeline's single-word data memory.
- Adds byte/halfword/word loads and stores with little-endian lane selection, sign or zero extension on loads, and misaligned/out-of-range detection.
- Adds a configurable access latency behind a valid/ready request handshake, so the MEM stage can stall on `req_ready` and wait for `resp_valid`.

Parameters:
- DEPTH, 64, number of 32-bit words; must be a power of two, ≥4.
- LATENCY, 2, cycles from request acceptance to `resp_valid`; legal range 1..15.
- ADDR_W, 32, byte-address width.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset (block in reset while RST=0).
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- Address  input  ADDR_W  byte address.
- Write_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle pulse: access complete.
- Read_data  output  32  load result, valid with resp_valid.
- resp_err  output  1  access rejected, valid with resp_valid.

Behaviour:
- **Reset (RST=0, asynchronous):**
  - State forced to IDLE, cycle counter cleared.
  - Outputs: req_ready=1, resp_valid=0, Read_data=0, resp_err=0.
  - All DEPTH words cleared to 0.
  - A request in flight is dropped; no write occurs.
- **State machine:**
  - IDLE:
    - req_ready=1.
    - On `req_valid` at a clock edge, latch `req_write`, `req_size`, `req_unsigned`, `Address`, `Write_data` and evaluate the error check.
    - Error → go to RESP with err flag set.
    - Otherwise, LATENCY=1 → go to RESP directly; else go to BUSY with counter=LATENCY-1.
  - BUSY:
    - req_ready=0.
    - Counter decrements each cycle.
    - When the counter reaches 1 at an edge, go to RESP.
  - RESP:
    - req_ready=0, resp_valid=1 for exactly one cycle, then IDLE.
    - No new request is accepted in RESP.
    - Sustained throughput: one access per LATENCY+1 cycles.
- **Timing:** resp_valid rises exactly LATENCY cycles after the acceptance edge, or 1 cycle after it for errors.
- **Memory effects:**
  - The store write and the load sample both happen on the edge entering RESP.
  - A store becomes visible to a load accepted afterwards.
- **Error check (resp_err=1, no write, Read_data=0):**
  - req_size=11.
  - Half with Address[0]=1.
  - Word with Address[1:0]≠0.
  - Word index Address>>2 ≥ DEPTH, i.e. any upper bit set above log2(DEPTH)+2.
- **Stores (write only the addressed lanes; other bytes preserved):**
  - Byte: Write_data[7:0] → lane Address[1:0].
  - Half: Write_data[15:0] → lanes {Address[1],0} (low byte) and {Address[1],1} (high byte).
  - Word: all four lanes.
- **Loads:**
  - Extract the addressed byte/half and place it in the low bits.
  - Upper bits are copies of the MSB when req_unsigned=0, zeros when req_unsigned=1.
  - Word loads are returned unmodified.
- **Stores do not update Read_data:** Read_data=0 on store responses and when resp_valid=0.
- **Input stability:** changes on request inputs after acceptance are ignored (latched copies are used).
- **Reset mid-operation:** RST low during BUSY or RESP aborts the access, suppresses resp_valid, and returns the block to the reset state above.

Test Plan:
- **Reset and word store/load:** hold RST=0 for 2 cycles, release; store word 0xDEADBEEF at 0x10, LATENCY=2.
  - resp_valid pulses 2 cycles after acceptance.
  - A word load from 0x10 returns 0xDEADBEEF.
  - A word load from 0x14 returns 0.
- **Byte lanes and extension:** store byte 0x80 at 0x21, then load byte from 0x21.
  - Signed load → 0xFFFFFF80; unsigned load → 0x00000080.
  - Word load from 0x20 → 0x00008000.
- **Halfword stores:**
  - Store half 0x1234 at 0x32 over existing word 0xAABBCCDD → word reads 0x1234CCDD.
  - Signed half load from 0x32 → 0x00001234.
- **Errors:**
  - Word store at 0x06 → resp_err=1 one cycle after acceptance; memory unchanged.
  - Half load at 0x03 → resp_err=1, Read_data=0.
  - Word load at 0x100 with DEPTH=64 → resp_err=1.
  - req_size=11 → resp_err=1.
- **Handshake/back-to-back:** hold req_valid=1 for 8 cycles with LATENCY=3.
  - req_ready low in BUSY and RESP.
  - Exactly 2 acceptances, each followed by resp_valid 3 cycles later.
  - Repeat with LATENCY=1: ready/valid alternate every cycle.
- **Reset mid-op:** assert RST=0 one cycle after accepting a word store of 0x55 at 0x40.
  - No resp_valid.
  - After release, a load from 0x40 returns 0 and req_ready=1.

Source files
------------

// File: rtl/data_memory_mc.sv
// Multi-cycle byte-addressable data memory with a valid/ready request port,
// sub-word little-endian access, load extension and error reporting.
module data_memory_mc #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       Write_data,
  output logic              resp_valid,
  output logic [31:0]       Read_data,
  output logic              resp_err
);

  localparam int unsigned IdxW    = $clog2(DEPTH);
  localparam logic [3:0]  LatInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic              write_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic [31:0] mem_q [DEPTH];

  logic accept;
  logic go_resp;
  logic commit;

  // In IDLE the access is taken straight from the port so that error and
  // single-cycle requests can complete on the acceptance edge itself.
  logic              acc_write;
  logic [1:0]        acc_size;
  logic              acc_uns;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic              acc_err;
  logic [IdxW-1:0]   acc_idx;

  always_comb begin
    if (state_q == StIdle) begin
      acc_write = req_write;
      acc_size  = req_size;
      acc_uns   = req_unsigned;
      acc_addr  = Address;
      acc_wdata = Write_data;
    end else begin
      acc_write = write_q;
      acc_size  = size_q;
      acc_uns   = uns_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  assign acc_idx = acc_addr[IdxW+1:2];

  always_comb begin
    acc_err = 1'b0;
    unique case (acc_size)
      2'b00:   acc_err = 1'b0;
      2'b01:   acc_err = acc_addr[0];
      2'b10:   acc_err = (acc_addr[1:0] != 2'b00);
      default: acc_err = 1'b1;
    endcase
    if ((acc_addr >> (IdxW + 2)) != '0) begin
      acc_err = 1'b1;
    end
  end

  // Store lane enables and lane-replicated write word.
  logic [3:0]  wr_be;
  logic [31:0] wr_word;

  always_comb begin
    wr_be   = 4'b0000;
    wr_word = '0;
    unique case (acc_size)
      2'b00: begin
        wr_be   = 4'b0001 << acc_addr[1:0];
        wr_word = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{acc_wdata[15:0]}};
      end
      2'b10: begin
        wr_be   = 4'b1111;
        wr_word = acc_wdata;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_word = '0;
      end
    endcase
  end

  // Load lane extraction and extension.
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;

  assign rd_word = mem_q[acc_idx];
  assign rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rd_byte = rd_word[7:0];
    unique case (acc_addr[1:0])
      2'b00:   rd_byte = rd_word[7:0];
      2'b01:   rd_byte = rd_word[15:8];
      2'b10:   rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
  end

  always_comb begin
    load_val = rd_word;
    unique case (acc_size)
      2'b00:   load_val = acc_uns ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_val = acc_uns ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_val = rd_word;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    go_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept = 1'b1;
          if (acc_err || (LATENCY == 1)) begin
            state_d = StResp;
            go_resp = 1'b1;
          end else begin
            state_d = StBusy;
            cnt_d   = LatInit;
          end
        end
      end
      StBusy: begin
        if (cnt_q == 4'd1) begin
          state_d = StResp;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign commit = go_resp && !acc_err;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      write_q <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= Address;
        wdata_q <= Write_data;
      end
      if (go_resp) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || acc_write) ? 32'h0 : load_val;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[IdxW'(i)] <= '0;
      end
    end else if (commit && acc_write) begin
      if (wr_be[0]) mem_q[acc_idx][7:0]   <= wr_word[7:0];
      if (wr_be[1]) mem_q[acc_idx][15:8]  <= wr_word[15:8];
      if (wr_be[2]) mem_q[acc_idx][23:16] <= wr_word[23:16];
      if (wr_be[3]) mem_q[acc_idx][31:24] <= wr_word[31:24];
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_err   = (state_q == StResp) && err_q;
  assign Read_data  = (state_q == StResp) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_data_memory_mc.sv
// Bench for data_memory_mc: three instances (LATENCY 1, 2, 3) share one request
// stream and are checked against a byte-array transaction model.
module tb_data_memory_mc;

  localparam int unsigned Depth = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [2:0]  rdy;
  logic [2:0]  vld;
  logic [2:0]  rerr;
  logic [31:0] rd [3];

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] mem_m [4*Depth];

  always #5 clk = ~clk;

  data_memory_mc #(.DEPTH(Depth), .LATENCY(1), .ADDR_W(32)) u_dut_l1 (
    .CLK(clk), .RST(rst), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .Address(addr), .Write_data(wdata), .resp_valid(vld[0]), .Read_data(rd[0]),
    .resp_err(rerr[0])
  );

  data_memory_mc #(.DEPTH(Depth), .LATENCY(2), .ADDR_W(32)) u_dut_l2 (
    .CLK(clk), .RST(rst), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .Address(addr), .Write_data(wdata), .resp_valid(vld[1]), .Read_data(rd[1]),
    .resp_err(rerr[1])
  );

  data_memory_mc #(.DEPTH(Depth), .LATENCY(3), .ADDR_W(32)) u_dut_l3 (
    .CLK(clk), .RST(rst), .req_valid(req_valid), .req_ready(rdy[2]),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .Address(addr), .Write_data(wdata), .resp_valid(vld[2]), .Read_data(rd[2]),
    .resp_err(rerr[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic string tg(input int d, input string s);
    return $sformatf("L%0d %s", d + 1, s);
  endfunction

  // Transaction-level model: little-endian byte array.
  function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0)
           || (a >= 4 * Depth);
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a);
    int unsigned i;
    int unsigned v;
    i = a % (4 * Depth);
    if (sz == 2'b00) begin
      v = 32'(mem_m[i]);
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = 32'(mem_m[i]) + 256 * 32'(mem_m[i+1]);
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = 32'(mem_m[i]) + 256 * 32'(mem_m[i+1]) + 65536 * 32'(mem_m[i+2])
          + 16777216 * 32'(mem_m[i+3]);
    end
    return v;
  endfunction

  task automatic m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int unsigned i;
    int unsigned n;
    i = a % (4 * Depth);
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int unsigned k = 0; k < n; k++) begin
      mem_m[i+k] = 8'((wd >> (8 * k)) % 256);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < 4 * Depth; i++) mem_m[i] = 8'h00;
  endtask

  task automatic check_idle(input string s);
    for (int d = 0; d < 3; d++) begin
      check(tg(d, {s, " req_ready"}), 32'(rdy[d]), 32'd1);
      check(tg(d, {s, " resp_valid"}), 32'(vld[d]), 32'd0);
      check(tg(d, {s, " Read_data"}), rd[d], 32'd0);
      check(tg(d, {s, " resp_err"}), 32'(rerr[d]), 32'd0);
    end
  endtask

  // One request, then a cycle-by-cycle check of every instance's response window.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
    logic        e;
    logic [31:0] exp_rd;
    int          el;
    string       s;
    e      = m_err(sz, a);
    exp_rd = (e || w) ? 32'h0 : m_load(sz, uns, a);
    if (!e && w) m_store(sz, a, wd);
    s = $sformatf("%s sz%0d @%08h", w ? "st" : "ld", sz, a);
    @(negedge clk);
    for (int d = 0; d < 3; d++) check(tg(d, {s, " ready before"}), 32'(rdy[d]), 32'd1);
    req_write    = w;
    req_size     = sz;
    req_unsigned = uns;
    addr         = a;
    wdata        = wd;
    req_valid    = 1'b1;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_write    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    addr         = $urandom;
    wdata        = $urandom;
    for (int k = 1; k <= 5; k++) begin
      for (int d = 0; d < 3; d++) begin
        el = e ? 1 : d + 1;
        check(tg(d, $sformatf("%s c%0d resp_valid", s, k)), 32'(vld[d]), 32'(k == el));
        check(tg(d, $sformatf("%s c%0d req_ready", s, k)), 32'(rdy[d]), 32'(k > el));
        check(tg(d, $sformatf("%s c%0d Read_data", s, k)), rd[d], (k == el) ? exp_rd : 32'h0);
        check(tg(d, $sformatf("%s c%0d resp_err", s, k)), 32'(rerr[d]), 32'(k == el && e));
      end
      if (k < 5) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  // req_valid held for 8 edges; expected schedule derived from one access per L+1 cycles.
  task automatic b2b();
    logic        bz [3][20];
    logic        rp [3][20];
    int          nacc_e [3];
    int          nacc_o [3];
    int          nf;
    logic [31:0] exp;
    exp = m_load(2'b10, 1'b0, 32'h10);
    for (int d = 0; d < 3; d++) begin
      nacc_e[d] = 0;
      nacc_o[d] = 0;
      for (int e = 0; e < 20; e++) begin
        bz[d][e] = 1'b0;
        rp[d][e] = 1'b0;
      end
      nf = 0;
      for (int e = 0; e < 8; e++) begin
        if (e >= nf) begin
          nacc_e[d]++;
          for (int j = 0; j <= d; j++) bz[d][e+j] = 1'b1;
          rp[d][e+d] = 1'b1;
          nf = e + d + 2;
        end
      end
    end
    @(negedge clk);
    req_write    = 1'b0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    addr         = 32'h10;
    req_valid    = 1'b1;
    for (int e = 0; e < 12; e++) begin
      for (int d = 0; d < 3; d++) if (req_valid && rdy[d]) nacc_o[d]++;
      @(posedge clk);
      #1;
      if (e == 7) req_valid = 1'b0;
      for (int d = 0; d < 3; d++) begin
        check(tg(d, $sformatf("b2b e%0d resp_valid", e)), 32'(vld[d]), 32'(rp[d][e]));
        check(tg(d, $sformatf("b2b e%0d req_ready", e)), 32'(rdy[d]), 32'(!bz[d][e]));
        check(tg(d, $sformatf("b2b e%0d Read_data", e)), rd[d], rp[d][e] ? exp : 32'h0);
      end
      @(negedge clk);
    end
    for (int d = 0; d < 3; d++) check(tg(d, "b2b acceptances"), nacc_o[d], nacc_e[d]);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    rst          = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    addr         = '0;
    wdata        = '0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    check_idle("in reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle("after reset");

    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    run_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);

    run_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_0080);
    run_req(1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
    run_req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
    run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

    run_req(1'b1, 2'b10, 1'b0, 32'h30, 32'hAABB_CCDD);
    run_req(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000_1234);
    run_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    run_req(1'b0, 2'b01, 1'b0, 32'h32, 32'h0);

    run_req(1'b1, 2'b10, 1'b0, 32'h06, 32'h1111_2222);
    run_req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
    run_req(1'b0, 2'b01, 1'b0, 32'h03, 32'h0);
    run_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    run_req(1'b0, 2'b11, 1'b0, 32'h08, 32'h0);

    b2b();

    // Reset during an in-flight word store.
    @(negedge clk);
    req_write = 1'b1;
    req_size  = 2'b10;
    addr      = 32'h40;
    wdata     = 32'h55;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int d = 1; d < 3; d++) check(tg(d, "midop resp_valid"), 32'(vld[d]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_clear();
    #1;
    check_idle("midop reset");
    repeat (2) @(posedge clk);
    #1;
    check_idle("midop held");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle("midop release");
    run_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

    repeat (150) begin
      sz = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4 * Depth - 1));
      if ($urandom_range(0, 1) == 1) begin
        if (sz == 2'b01) a = a & ~32'd1;
        if (sz == 2'b10) a = a & ~32'd3;
      end
      run_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
